div_seq_ctrl: RTL and testbench
===============================

// Module: div_seq_ctrl
// PURPOSE
//  Sequencer for the serial remainder (divisibility) datapath. Accepts parallel words over a
//  valid/ready handshake and feeds them MSB-first, one bit per clock, into a mod-DIVISOR step.
//  Returns divisible flag plus final remainder over a second valid/ready handshake.
//  Sits between a word-wide producer and the consumer of divisibility results.
// PARAMETERS
//  WORD_W    8   bits per input word (>=1)
//  DIVISOR   3   modulus (>=2)
//  REM_W     $clog2(DIVISOR)  remainder width (derived, not overridden)
//  COUNT_W   16  width of divisible-result counter
// PORTS
//  clk           in   1        single clock, rising edge
//  reset         in   1        asynchronous, active-high
//  clear_i       in   1        synchronous abort of in-flight word
//  in_valid_i    in   1        input word valid
//  in_ready_o    out  1        controller can accept a word this cycle
//  in_data_i     in   WORD_W   word, bit WORD_W-1 processed first
//  out_valid_o   out  1        result valid
//  out_ready_i   in   1        consumer accepts result
//  out_div_o     out  1        1 = word mod DIVISOR == 0
//  out_rem_o     out  REM_W    word mod DIVISOR
//  busy_o        out  1        state != IDLE
//  div_count_o   out  COUNT_W  number of handshaken results with out_div_o=1
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, shift reg=0, rem=0, bit cnt=0, out_valid_o=0,
//   out_div_o=0, out_rem_o=0, busy_o=0, div_count_o=0. in_ready_o=1 once reset deasserts.
//  Step function: rem_next = (2*rem + bit) mod DIVISOR; rem is REM_W wide, always < DIVISOR.
//  FSM states IDLE, SHIFT, DONE:
//   IDLE : in_ready_o=1. in_valid_i&in_ready_o -> load shift reg, rem=0, cnt=WORD_W -> SHIFT.
//   SHIFT: each edge consumes MSB, shifts left, rem<=rem_next, cnt--. Edge with cnt==1 -> DONE.
//          in_ready_o=0.
//   DONE : out_valid_o=1; out_div_o=(rem==0), out_rem_o=rem held stable until handshake.
//          out_valid_o&out_ready_i -> IDLE, or -> SHIFT if in_valid_i also high
//          (load on the same edge).
//  in_ready_o = (IDLE) | (DONE & out_ready_i); only combinational path is out_ready_i->in_ready_o.
//  Latency: out_valid_o rises exactly WORD_W edges after the accepting edge. Back-to-back period
//   with out_ready_i=1 is WORD_W+1 cycles per word.
//  Backpressure: out_ready_i=0 in DONE stalls indefinitely; outputs and in_ready_o=0 held.
//  clear_i: highest synchronous priority; next edge -> IDLE, rem/cnt/shift cleared, out_valid_o=0,
//   no handshake counted; in_ready_o=0 in any cycle clear_i=1. div_count_o unaffected.
//  div_count_o increments on each output handshake with out_div_o=1; saturates at all-ones.
//  out_div_o/out_rem_o are 0 whenever out_valid_o=0.
//  WORD_W=1: SHIFT lasts one edge; all rules unchanged.
//  Reset asserted mid-SHIFT/DONE: word discarded, reset values above, no output.
// STRUCTURE
//  Package div_seq_pkg: typedef enum logic [1:0] {IDLE, SHIFT, DONE} div_state_t.
//   Also holds the REM_W derivation function.
//  Sub-module mod_n_step (combinational): params DIVISOR, REM_W; in rem, bit; out rem_next.
//   Top holds FSM, shift reg, $clog2(WORD_W+1)-bit counter, remainder reg, result counter.
// TESTING
//  1 Reset: assert reset between edges -> all outputs reset values immediately. Release -> in_ready_o=1.
//  2 WORD_W=8, DIVISOR=3 words 0x06, 0x07, 0xFF, 0x00. Expected div/rem: 1/0, 0/1, 1/0, 1/0.
//    out_valid_o 8 edges after each accept; div_count_o=3.
//  3 Backpressure: out_ready_i=0 for 5 cycles in DONE -> outputs stable, in_ready_o=0.
//    Pending input held until handshake.
//  4 Back-to-back 0x09 then 0x0A, out_ready_i=1 -> second accepted on first result's handshake edge.
//    Results 1/0 then 0/1, period 9 cycles.
//  5 clear_i on 3rd SHIFT cycle of 0x0C -> IDLE next edge, no out_valid_o, div_count_o unchanged.
//    Next word 0x03 -> 1/0.
//  6 COUNT_W=2, five divisible words (0x00,0x03,0x06,0x09,0x0C) -> div_count_o 1,2,3,3,3.
//    DIVISOR=5 word 0x0E -> rem 4.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared types and width helpers for the serial divisibility sequencer.
// The remainder width is derived from the modulus so instances never override it.
package div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } div_state_t;

  // Narrowest register that holds 0..divisor-1; a modulus of 2 still needs one bit.
  function automatic int rem_width(input int divisor);
    return (divisor <= 2) ? 1 : $clog2(divisor);
  endfunction

endpackage

// File: rtl/div_seq_ctrl_mod_n_step.sv
// One MSB-first step of the serial remainder: rem_next = (2*rem + bit) mod DIVISOR.
// Since rem < DIVISOR the doubled value is below 2*DIVISOR, so one conditional subtract suffices.
module mod_n_step #(
  parameter int DIVISOR = 3,
  parameter int REM_W   = 2
) (
  input  logic [REM_W-1:0] i_rem,
  input  logic             i_bit,
  output logic [REM_W-1:0] o_rem_next
);

  localparam logic [REM_W:0] DIV_VAL = (REM_W+1)'(DIVISOR);

  logic [REM_W:0] w_twice;

  assign w_twice    = {i_rem, i_bit};
  assign o_rem_next = (w_twice >= DIV_VAL) ? REM_W'(w_twice - DIV_VAL) : REM_W'(w_twice);

endmodule

// File: rtl/div_seq_ctrl.sv
// Accepts parallel words, shifts them MSB-first through a mod-DIVISOR step and
// returns the divisibility flag and remainder over a valid/ready result handshake.
module div_seq_ctrl
  import div_seq_pkg::*;
#(
  parameter  int WORD_W  = 8,
  parameter  int DIVISOR = 3,
  parameter  int COUNT_W = 16,
  localparam int REM_W   = rem_width(DIVISOR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WORD_W-1:0]  in_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               out_div_o,
  output logic [REM_W-1:0]   out_rem_o,
  output logic               busy_o,
  output logic [COUNT_W-1:0] div_count_o
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  div_state_t         r_state;
  logic [WORD_W-1:0]  r_shift;
  logic [REM_W-1:0]   r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic               r_out_div;
  logic [REM_W-1:0]   r_out_rem;
  logic [COUNT_W-1:0] r_div_count;

  logic [REM_W-1:0]   w_rem_next;
  logic               w_accept;
  logic               w_out_hs;

  mod_n_step #(
    .DIVISOR (DIVISOR),
    .REM_W   (REM_W)
  ) u_step (
    .i_rem      (r_rem),
    .i_bit      (r_shift[WORD_W-1]),
    .o_rem_next (w_rem_next)
  );

  // A result being taken frees the slot on the same edge, hence the out_ready_i path.
  assign in_ready_o = ~clear_i & ((r_state == IDLE) | ((r_state == DONE) & out_ready_i));
  assign w_accept   = in_valid_i & in_ready_o;
  assign w_out_hs   = r_out_valid & out_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_div   <= 1'b0;
      r_out_rem   <= '0;
      r_div_count <= '0;
    end else if (clear_i) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_div   <= 1'b0;
      r_out_rem   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= in_data_i;
            r_rem   <= '0;
            r_cnt   <= CNT_W'(WORD_W);
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          r_shift <= r_shift << 1;
          r_rem   <= w_rem_next;
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out_div   <= (w_rem_next == '0);
            r_out_rem   <= w_rem_next;
          end
        end

        DONE: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_div   <= 1'b0;
            r_out_rem   <= '0;
            if (r_out_div && (r_div_count != {COUNT_W{1'b1}}))
              r_div_count <= r_div_count + COUNT_W'(1);
            if (w_accept) begin
              r_shift <= in_data_i;
              r_rem   <= '0;
              r_cnt   <= CNT_W'(WORD_W);
              r_state <= SHIFT;
            end else begin
              r_state <= IDLE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_div_o   = r_out_div;
  assign out_rem_o   = r_out_rem;
  assign busy_o      = (r_state != IDLE);
  assign div_count_o = r_div_count;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench: three instances (mod 3, mod 3 with 2-bit counter, mod 5) share one input stream.
module tb_div_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic        in_ready0, out_valid0, out_div0, busy0;
  logic [1:0]  out_rem0;
  logic [15:0] cnt0;
  logic        in_ready1, out_valid1, out_div1, busy1;
  logic [1:0]  out_rem1;
  logic [1:0]  cnt1;
  logic        in_ready2, out_valid2, out_div2, busy2;
  logic [2:0]  out_rem2;
  logic [15:0] cnt2;

  int checks   = 0;
  int failures = 0;
  logic [2:0] last_rem5;

  div_seq_ctrl #(.WORD_W(8), .DIVISOR(3), .COUNT_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .in_data_i(in_data), .out_valid_o(out_valid0), .out_ready_i(out_ready), .out_div_o(out_div0),
    .out_rem_o(out_rem0), .busy_o(busy0), .div_count_o(cnt0));

  div_seq_ctrl #(.WORD_W(8), .DIVISOR(3), .COUNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .in_data_i(in_data), .out_valid_o(out_valid1), .out_ready_i(out_ready), .out_div_o(out_div1),
    .out_rem_o(out_rem1), .busy_o(busy1), .div_count_o(cnt1));

  div_seq_ctrl #(.WORD_W(8), .DIVISOR(5), .COUNT_W(16)) u_dut2 (
    .clk(clk), .reset(reset), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .in_data_i(in_data), .out_valid_o(out_valid2), .out_ready_i(out_ready), .out_div_o(out_div2),
    .out_rem_o(out_rem2), .busy_o(busy2), .div_count_o(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word from IDLE with out_ready high, check latency and result, complete handshake.
  task automatic run_word(input logic [7:0] d, input logic ed, input logic [1:0] er, input string tag);
    int n;
    chk({tag, "_rdy"}, 32'(in_ready0), 1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_div"}, 32'(out_div0), 32'(ed));
    chk({tag, "_rem"}, 32'(out_rem0), 32'(er));
    last_rem5 = out_rem2;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic seen;
    logic [7:0] t6_words [5];
    logic [1:0] t6_cnt   [5];
    t6_words = '{8'h00, 8'h03, 8'h06, 8'h09, 8'h0C};
    t6_cnt   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    last_rem5 = '0;
    #12 reset = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready0), 1);
    chk("rst_outs", 32'({out_valid0, out_div0, out_rem0, busy0}), 0);
    chk("rst_count", 32'(cnt0), 0);

    // Basic words
    run_word(8'h06, 1'b1, 2'd0, "w06");
    run_word(8'h07, 1'b0, 2'd1, "w07");
    run_word(8'hFF, 1'b1, 2'd0, "wFF");
    run_word(8'h00, 1'b1, 2'd0, "w00");
    chk("cnt_after_basic", 32'(cnt0), 3);

    // Backpressure with a pending word
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h05;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid0 && n < 20) begin tick(); n++; end
    chk("bp_lat", n, 8);
    in_valid = 1'b1; in_data = 8'h06;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", 32'({out_valid0, out_div0, out_rem0, in_ready0}), 32'(5'b1_0_10_0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(in_ready0), 1);
    tick();
    in_valid = 1'b0;
    chk("bp_reload", 32'({out_valid0, busy0}), 32'(2'b01));
    n = 0;
    while (!out_valid0 && n < 20) begin tick(); n++; end
    chk("bp2_lat", n, 8);
    chk("bp2_res", 32'({out_div0, out_rem0}), 32'(3'b1_00));
    tick();
    chk("bp_count", 32'(cnt0), 4);

    // Back-to-back 0x09 then 0x0A
    in_valid = 1'b1; in_data = 8'h09;
    tick();
    in_data = 8'h0A;
    n = 0;
    while (!out_valid0 && n < 20) begin tick(); n++; end
    chk("b2b_lat1", n, 8);
    chk("b2b_res1", 32'({out_div0, out_rem0, in_ready0}), 32'(4'b1_00_1));
    tick();
    n++;
    in_valid = 1'b0;
    chk("b2b_load", 32'({out_valid0, busy0}), 32'(2'b01));
    while (!out_valid0 && n < 40) begin tick(); n++; end
    chk("b2b_lat2", n, 17);
    chk("b2b_res2", 32'({out_div0, out_rem0}), 32'(3'b0_01));
    tick();
    chk("b2b_count", 32'(cnt0), 5);

    // clear_i on the third SHIFT cycle
    in_valid = 1'b1; in_data = 8'h0C;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    #1;
    chk("clr_ready_low", 32'(in_ready0), 0);
    tick();
    clear = 1'b0;
    chk("clr_idle", 32'({busy0, out_valid0, out_rem0}), 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid0) seen = 1'b1;
    end
    chk("clr_no_valid", 32'(seen), 0);
    chk("clr_count", 32'(cnt0), 5);
    run_word(8'h03, 1'b1, 2'd0, "w03");
    chk("post_clr_count", 32'(cnt0), 6);

    // Reset asserted mid-SHIFT takes effect immediately
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_outs", 32'({busy0, out_valid0, out_div0}), 0);
    chk("rst_mid_count", 32'(cnt0), 0);
    chk("rst_mid_count1", 32'(cnt1), 0);
    #2 reset = 1'b0;
    tick();
    chk("rst_mid_release", 32'({in_ready0, busy0}), 32'(2'b10));

    // Saturating 2-bit counter and mod-5 remainder
    for (int i = 0; i < 5; i++) begin
      run_word(t6_words[i], 1'b1, 2'd0, "t6");
      chk("sat_count", 32'(cnt1), 32'(t6_cnt[i]));
    end
    chk("mod5_0C", 32'(last_rem5), 2);
    run_word(8'h0E, 1'b0, 2'd2, "w0E");
    chk("mod5_0E", 32'(last_rem5), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
